bsg_blackparrot_mc_credit_endpoint: RTL and testbench

- Single-clock manycore-side endpoint that sits on one proc link of the horizontal IO router column, on the manycore clock side of the async link CDC.
- Issues forward (request) packets from a client onto the fwd link and accepts reverse (response) packets into a buffer.
- Tracks outstanding requests with a credit counter.
- Provides a fence/drain handshake so the client can wait for all responses before reconfiguration.

---
 rtl/bsg_blackparrot_mc_endpoint_pkg.sv | 16 +
 rtl/bsg_blackparrot_mc_credit_counter.sv | 46 ++++
 rtl/bsg_fifo_1r1w_small.sv | 59 +++++
 rtl/bsg_two_fifo.sv | 26 ++
 rtl/bsg_blackparrot_mc_credit_endpoint.sv | 83 ++++++++
 tb/tb_bsg_blackparrot_mc_credit_endpoint.sv | 263 ++++++++++++++++++++++++++
 6 files changed

// File: rtl/bsg_blackparrot_mc_endpoint_pkg.sv
// Shared widths and credit constants for the manycore-side BlackParrot credit endpoint.
package bsg_blackparrot_mc_endpoint_pkg;

  localparam int unsigned fwd_width_gp       = 96;
  localparam int unsigned rev_width_gp       = 48;
  localparam int unsigned max_out_credits_gp = 16;
  localparam int unsigned rev_fifo_els_gp    = 4;

  // Bits needed to hold the values 0..x inclusive.
  function automatic int unsigned bsg_width_f(input int unsigned x);
    return $clog2(x + 1);
  endfunction

  localparam int unsigned credit_width_gp = bsg_width_f(max_out_credits_gp);

endpackage

// File: rtl/bsg_blackparrot_mc_credit_counter.sv
// Up/down credit counter that saturates at both ends and flags underflow stickily.
module bsg_blackparrot_mc_credit_counter
  import bsg_blackparrot_mc_endpoint_pkg::*;
#(
  parameter int unsigned max_val_p = max_out_credits_gp,
  parameter int unsigned width_p   = bsg_width_f(max_val_p)
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               up_i,
  input  logic               down_i,
  output logic [width_p-1:0] count_o,
  output logic               error_o
);

  logic [width_p-1:0] count_q, count_d;
  logic               error_q, error_d;

  always_comb begin
    count_d = count_q;
    error_d = error_q;
    case ({up_i, down_i})
      2'b10: if (count_q != width_p'(max_val_p)) count_d = count_q + width_p'(1);
      2'b01: begin
        // A return with nothing outstanding is a protocol error, not a wrap.
        if (count_q == '0) error_d = 1'b1;
        else               count_d = count_q - width_p'(1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      count_q <= '0;
      error_q <= 1'b0;
    end else begin
      count_q <= count_d;
      error_q <= error_d;
    end
  end

  assign count_o = count_q;
  assign error_o = error_q;

endmodule

// File: rtl/bsg_fifo_1r1w_small.sv
// Small circular-buffer FIFO; ready/valid come straight from registered occupancy, no bypass.
module bsg_fifo_1r1w_small #(
  parameter int unsigned width_p = 8,
  parameter int unsigned els_p   = 4
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               v_i,
  input  logic [width_p-1:0] data_i,
  output logic               ready_and_o,
  output logic               v_o,
  output logic [width_p-1:0] data_o,
  input  logic               yumi_i
);

  localparam int unsigned ptr_w_lp = (els_p > 1) ? $clog2(els_p) : 1;
  localparam int unsigned cnt_w_lp = $clog2(els_p + 1);

  logic [width_p-1:0]  mem_q [els_p];
  logic [ptr_w_lp-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [cnt_w_lp-1:0] count_q, count_d;
  logic                enq, deq;

  assign ready_and_o = (count_q != cnt_w_lp'(els_p));
  assign v_o         = (count_q != '0);
  assign data_o      = mem_q[rd_ptr_q];
  assign enq         = v_i & ready_and_o;
  assign deq         = yumi_i & v_o;

  function automatic logic [ptr_w_lp-1:0] ptr_incr(input logic [ptr_w_lp-1:0] p);
    return (p == ptr_w_lp'(els_p - 1)) ? '0 : p + ptr_w_lp'(1);
  endfunction

  always_comb begin
    wr_ptr_d = enq ? ptr_incr(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = deq ? ptr_incr(rd_ptr_q) : rd_ptr_q;
    count_d  = count_q;
    if (enq & ~deq)      count_d = count_q + cnt_w_lp'(1);
    else if (~enq & deq) count_d = count_q - cnt_w_lp'(1);
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk_i) begin
    if (enq) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/bsg_two_fifo.sv
// Two-entry registered buffer: full throughput with a fully registered ready.
module bsg_two_fifo #(
  parameter int unsigned width_p = 8
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               v_i,
  input  logic [width_p-1:0] data_i,
  output logic               ready_and_o,
  output logic               v_o,
  output logic [width_p-1:0] data_o,
  input  logic               yumi_i
);

  bsg_fifo_1r1w_small #(.width_p(width_p), .els_p(2)) fifo (
    .clk_i      (clk_i),
    .reset_n_i  (reset_n_i),
    .v_i        (v_i),
    .data_i     (data_i),
    .ready_and_o(ready_and_o),
    .v_o        (v_o),
    .data_o     (data_o),
    .yumi_i     (yumi_i)
  );

endmodule

// File: rtl/bsg_blackparrot_mc_credit_endpoint.sv
// Manycore-side proc-link endpoint: credit-limited request issue, buffered responses, fence/drain.
module bsg_blackparrot_mc_credit_endpoint
  import bsg_blackparrot_mc_endpoint_pkg::*;
#(
  parameter int unsigned fwd_width_p       = fwd_width_gp,
  parameter int unsigned rev_width_p       = rev_width_gp,
  parameter int unsigned max_out_credits_p = max_out_credits_gp,
  parameter int unsigned rev_fifo_els_p    = rev_fifo_els_gp,
  localparam int unsigned credit_width_lp  = bsg_width_f(max_out_credits_p)
) (
  input  logic                       clk_i,
  input  logic                       reset_n_i,
  input  logic                       req_v_i,
  input  logic [fwd_width_p-1:0]     req_data_i,
  output logic                       req_ready_and_o,
  output logic                       fwd_v_o,
  output logic [fwd_width_p-1:0]     fwd_data_o,
  input  logic                       fwd_ready_and_i,
  input  logic                       rev_v_i,
  input  logic [rev_width_p-1:0]     rev_data_i,
  output logic                       rev_ready_and_o,
  output logic                       resp_v_o,
  output logic [rev_width_p-1:0]     resp_data_o,
  input  logic                       resp_yumi_i,
  input  logic                       fence_i,
  output logic                       fence_done_o,
  output logic [credit_width_lp-1:0] credits_used_o,
  output logic                       error_o
);

  logic fwd_fifo_ready, rev_fifo_ready;
  logic req_accept, rev_accept;
  logic rev_en_q;

  // Holds rev_ready low until the first edge after reset is released.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) rev_en_q <= 1'b0;
    else            rev_en_q <= 1'b1;
  end

  assign req_ready_and_o = fwd_fifo_ready
                         & (credits_used_o < credit_width_lp'(max_out_credits_p))
                         & ~fence_i;
  assign req_accept      = req_v_i & req_ready_and_o;
  assign rev_ready_and_o = rev_fifo_ready & rev_en_q;
  assign rev_accept      = rev_v_i & rev_ready_and_o;
  assign fence_done_o    = (credits_used_o == '0) & ~fwd_v_o;

  bsg_two_fifo #(.width_p(fwd_width_p)) fwd_fifo (
    .clk_i      (clk_i),
    .reset_n_i  (reset_n_i),
    .v_i        (req_accept),
    .data_i     (req_data_i),
    .ready_and_o(fwd_fifo_ready),
    .v_o        (fwd_v_o),
    .data_o     (fwd_data_o),
    .yumi_i     (fwd_v_o & fwd_ready_and_i)
  );

  bsg_fifo_1r1w_small #(.width_p(rev_width_p), .els_p(rev_fifo_els_p)) rev_fifo (
    .clk_i      (clk_i),
    .reset_n_i  (reset_n_i),
    .v_i        (rev_accept),
    .data_i     (rev_data_i),
    .ready_and_o(rev_fifo_ready),
    .v_o        (resp_v_o),
    .data_o     (resp_data_o),
    .yumi_i     (resp_yumi_i)
  );

  bsg_blackparrot_mc_credit_counter #(
    .max_val_p(max_out_credits_p),
    .width_p  (credit_width_lp)
  ) credit_counter (
    .clk_i    (clk_i),
    .reset_n_i(reset_n_i),
    .up_i     (req_accept),
    .down_i   (rev_accept),
    .count_o  (credits_used_o),
    .error_o  (error_o)
  );

endmodule

// File: tb/tb_bsg_blackparrot_mc_credit_endpoint.sv
// Directed self-checking bench for the manycore credit endpoint.
module tb_bsg_blackparrot_mc_credit_endpoint;

  localparam int FW = 96;
  localparam int RW = 48;
  localparam int CW = 5;

  logic          clk_i = 1'b0;
  logic          reset_n_i = 1'b0;
  logic          req_v_i = 1'b0;
  logic [FW-1:0] req_data_i = '0;
  logic          req_ready_and_o;
  logic          fwd_v_o;
  logic [FW-1:0] fwd_data_o;
  logic          fwd_ready_and_i = 1'b1;
  logic          rev_v_i = 1'b0;
  logic [RW-1:0] rev_data_i = '0;
  logic          rev_ready_and_o;
  logic          resp_v_o;
  logic [RW-1:0] resp_data_o;
  logic          resp_yumi_i = 1'b0;
  logic          fence_i = 1'b0;
  logic          fence_done_o;
  logic [CW-1:0] credits_used_o;
  logic          error_o;

  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  bsg_blackparrot_mc_credit_endpoint dut (
    .clk_i(clk_i), .reset_n_i(reset_n_i),
    .req_v_i(req_v_i), .req_data_i(req_data_i), .req_ready_and_o(req_ready_and_o),
    .fwd_v_o(fwd_v_o), .fwd_data_o(fwd_data_o), .fwd_ready_and_i(fwd_ready_and_i),
    .rev_v_i(rev_v_i), .rev_data_i(rev_data_i), .rev_ready_and_o(rev_ready_and_o),
    .resp_v_o(resp_v_o), .resp_data_o(resp_data_o), .resp_yumi_i(resp_yumi_i),
    .fence_i(fence_i), .fence_done_o(fence_done_o),
    .credits_used_o(credits_used_o), .error_o(error_o)
  );

  task automatic tick(); @(posedge clk_i); #1; endtask
  task automatic mid();  @(negedge clk_i); endtask

  task automatic idle_inputs();
    req_v_i = 0; rev_v_i = 0; resp_yumi_i = 0; fence_i = 0; fwd_ready_and_i = 1;
  endtask

  task automatic do_reset();
    idle_inputs();
    #1 reset_n_i = 0;
    repeat (2) tick();
    reset_n_i = 1;
    tick();
  endtask

  task automatic test_reset();
    mid();
    checks++; if (rev_ready_and_o !== 1'b0) begin errors++; $display("FAIL rst_rev_ready: got %0b want 0", rev_ready_and_o); end
    checks++; if (fwd_v_o !== 1'b0) begin errors++; $display("FAIL rst_fwd_v: got %0b want 0", fwd_v_o); end
    checks++; if (resp_v_o !== 1'b0) begin errors++; $display("FAIL rst_resp_v: got %0b want 0", resp_v_o); end
    checks++; if (credits_used_o !== 5'd0) begin errors++; $display("FAIL rst_credits: got %0d want 0", credits_used_o); end
    checks++; if (fence_done_o !== 1'b1) begin errors++; $display("FAIL rst_fence_done: got %0b want 1", fence_done_o); end
    checks++; if (error_o !== 1'b0) begin errors++; $display("FAIL rst_error: got %0b want 0", error_o); end
    tick();
    reset_n_i = 1;
    mid();
    checks++; if (rev_ready_and_o !== 1'b0) begin errors++; $display("FAIL rst_rev_ready_before_edge: got %0b want 0", rev_ready_and_o); end
    tick(); mid();
    checks++; if (rev_ready_and_o !== 1'b1) begin errors++; $display("FAIL rst_rev_ready_after_edge: got %0b want 1", rev_ready_and_o); end
    // Three outstanding, then reset asynchronously mid-cycle.
    req_v_i = 1; req_data_i = 96'h11;
    repeat (3) tick();
    req_v_i = 0;
    mid();
    checks++; if (credits_used_o !== 5'd3) begin errors++; $display("FAIL rst_pre_credits: got %0d want 3", credits_used_o); end
    reset_n_i = 0;
    #1;
    checks++; if (credits_used_o !== 5'd0) begin errors++; $display("FAIL rst_mid_credits: got %0d want 0", credits_used_o); end
    checks++; if (fwd_v_o !== 1'b0) begin errors++; $display("FAIL rst_mid_fwd_v: got %0b want 0", fwd_v_o); end
    checks++; if (resp_v_o !== 1'b0) begin errors++; $display("FAIL rst_mid_resp_v: got %0b want 0", resp_v_o); end
    checks++; if (fence_done_o !== 1'b1) begin errors++; $display("FAIL rst_mid_fence_done: got %0b want 1", fence_done_o); end
    checks++; if (error_o !== 1'b0) begin errors++; $display("FAIL rst_mid_error: got %0b want 0", error_o); end
    checks++; if (rev_ready_and_o !== 1'b0) begin errors++; $display("FAIL rst_mid_rev_ready: got %0b want 0", rev_ready_and_o); end
    tick();
    reset_n_i = 1;
    tick();
  endtask

  task automatic test_credit_exhaustion();
    int acc = 0;
    int iss = 0;
    do_reset();
    req_v_i = 1; fwd_ready_and_i = 1;
    for (int i = 0; i < 20; i++) begin
      req_data_i = FW'(100 + i);
      mid();
      if (req_ready_and_o) acc++;
      if (fwd_v_o && fwd_ready_and_i) iss++;
      tick();
    end
    mid();
    checks++; if (acc !== 16) begin errors++; $display("FAIL exh_accepted: got %0d want 16", acc); end
    checks++; if (iss !== 16) begin errors++; $display("FAIL exh_issued: got %0d want 16", iss); end
    checks++; if (req_ready_and_o !== 1'b0) begin errors++; $display("FAIL exh_ready: got %0b want 0", req_ready_and_o); end
    checks++; if (credits_used_o !== 5'd16) begin errors++; $display("FAIL exh_credits: got %0d want 16", credits_used_o); end
    // Return at the limit: no same-cycle request acceptance.
    req_data_i = 96'h200; rev_v_i = 1; rev_data_i = 48'hBEEF;
    #1;
    checks++; if (req_ready_and_o !== 1'b0) begin errors++; $display("FAIL exh_ready_with_return: got %0b want 0", req_ready_and_o); end
    checks++; if (rev_ready_and_o !== 1'b1) begin errors++; $display("FAIL exh_rev_ready: got %0b want 1", rev_ready_and_o); end
    tick();
    rev_v_i = 0;
    mid();
    checks++; if (credits_used_o !== 5'd15) begin errors++; $display("FAIL exh_after_return_credits: got %0d want 15", credits_used_o); end
    checks++; if (req_ready_and_o !== 1'b1) begin errors++; $display("FAIL exh_after_return_ready: got %0b want 1", req_ready_and_o); end
    tick();
    req_v_i = 0;
    mid();
    checks++; if (credits_used_o !== 5'd16) begin errors++; $display("FAIL exh_17th_credits: got %0d want 16", credits_used_o); end
    checks++; if (fwd_v_o !== 1'b1 || fwd_data_o !== 96'h200) begin errors++; $display("FAIL exh_17th_fwd: got v=%0b data=%0h want v=1 data=200", fwd_v_o, fwd_data_o); end
  endtask

  task automatic test_simultaneous();
    do_reset();
    req_v_i = 1; req_data_i = 96'h55;
    repeat (5) tick();
    mid();
    checks++; if (credits_used_o !== 5'd5) begin errors++; $display("FAIL sim_pre_credits: got %0d want 5", credits_used_o); end
    rev_v_i = 1; rev_data_i = 48'h5;
    #1;
    checks++; if (req_ready_and_o !== 1'b1 || rev_ready_and_o !== 1'b1) begin errors++; $display("FAIL sim_both_ready: got req=%0b rev=%0b want 1 1", req_ready_and_o, rev_ready_and_o); end
    tick();
    req_v_i = 0; rev_v_i = 0;
    mid();
    checks++; if (credits_used_o !== 5'd5) begin errors++; $display("FAIL sim_credits: got %0d want 5", credits_used_o); end
    checks++; if (error_o !== 1'b0) begin errors++; $display("FAIL sim_error: got %0b want 0", error_o); end
    checks++; if (resp_v_o !== 1'b1 || resp_data_o !== 48'h5) begin errors++; $display("FAIL sim_resp: got v=%0b data=%0h want v=1 data=5", resp_v_o, resp_data_o); end
  endtask

  task automatic test_backpressure();
    logic [FW-1:0] pa, pb, pc;
    pa = 96'hAAAA_0001; pb = 96'hBBBB_0002; pc = 96'hCCCC_0003;
    do_reset();
    fwd_ready_and_i = 0; req_v_i = 1; req_data_i = pa;
    mid();
    checks++; if (req_ready_and_o !== 1'b1) begin errors++; $display("FAIL bp_ready_a: got %0b want 1", req_ready_and_o); end
    tick();
    req_data_i = pb;
    mid();
    checks++; if (fwd_v_o !== 1'b1 || fwd_data_o !== pa) begin errors++; $display("FAIL bp_head_a: got v=%0b data=%0h want v=1 data=%0h", fwd_v_o, fwd_data_o, pa); end
    tick();
    req_data_i = pc;
    for (int i = 0; i < 8; i++) begin
      mid();
      checks++; if (req_ready_and_o !== 1'b0) begin errors++; $display("FAIL bp_full_ready cyc%0d: got %0b want 0", i, req_ready_and_o); end
      checks++; if (fwd_v_o !== 1'b1 || fwd_data_o !== pa) begin errors++; $display("FAIL bp_stable cyc%0d: got v=%0b data=%0h want %0h", i, fwd_v_o, fwd_data_o, pa); end
      tick();
    end
    fwd_ready_and_i = 1;
    mid();
    checks++; if (req_ready_and_o !== 1'b0) begin errors++; $display("FAIL bp_release_ready: got %0b want 0", req_ready_and_o); end
    tick(); mid();
    checks++; if (fwd_v_o !== 1'b1 || fwd_data_o !== pb) begin errors++; $display("FAIL bp_out_b: got v=%0b data=%0h want %0h", fwd_v_o, fwd_data_o, pb); end
    checks++; if (req_ready_and_o !== 1'b1) begin errors++; $display("FAIL bp_ready_c: got %0b want 1", req_ready_and_o); end
    tick();
    req_v_i = 0;
    mid();
    checks++; if (fwd_v_o !== 1'b1 || fwd_data_o !== pc) begin errors++; $display("FAIL bp_out_c: got v=%0b data=%0h want %0h", fwd_v_o, fwd_data_o, pc); end
    tick(); mid();
    checks++; if (fwd_v_o !== 1'b0) begin errors++; $display("FAIL bp_drained: got %0b want 0", fwd_v_o); end
    checks++; if (credits_used_o !== 5'd3) begin errors++; $display("FAIL bp_credits: got %0d want 3", credits_used_o); end
  endtask

  task automatic test_rev_full();
    do_reset();
    req_v_i = 1; req_data_i = 96'h77;
    repeat (4) tick();
    req_v_i = 0;
    for (int i = 0; i < 4; i++) begin
      rev_v_i = 1; rev_data_i = RW'(48'h1000 + i);
      mid();
      checks++; if (rev_ready_and_o !== 1'b1) begin errors++; $display("FAIL rf_ready_%0d: got %0b want 1", i, rev_ready_and_o); end
      tick();
    end
    rev_data_i = 48'h1004;
    mid();
    checks++; if (rev_ready_and_o !== 1'b0) begin errors++; $display("FAIL rf_full_ready: got %0b want 0", rev_ready_and_o); end
    checks++; if (credits_used_o !== 5'd0 || error_o !== 1'b0) begin errors++; $display("FAIL rf_credits: got %0d err=%0b want 0 err=0", credits_used_o, error_o); end
    rev_v_i = 0; resp_yumi_i = 1;
    #1;
    checks++; if (rev_ready_and_o !== 1'b0) begin errors++; $display("FAIL rf_ready_during_deq: got %0b want 0", rev_ready_and_o); end
    checks++; if (resp_v_o !== 1'b1 || resp_data_o !== 48'h1000) begin errors++; $display("FAIL rf_resp_0: got v=%0b data=%0h want 1000", resp_v_o, resp_data_o); end
    tick(); mid();
    checks++; if (rev_ready_and_o !== 1'b1) begin errors++; $display("FAIL rf_ready_after_deq: got %0b want 1", rev_ready_and_o); end
    for (int i = 1; i < 4; i++) begin
      checks++; if (resp_v_o !== 1'b1 || resp_data_o !== RW'(48'h1000 + i)) begin errors++; $display("FAIL rf_resp_%0d: got v=%0b data=%0h want %0h", i, resp_v_o, resp_data_o, 48'h1000 + i); end
      tick(); mid();
    end
    resp_yumi_i = 0;
    checks++; if (resp_v_o !== 1'b0) begin errors++; $display("FAIL rf_empty: got %0b want 0", resp_v_o); end
  endtask

  task automatic test_fence_underflow();
    do_reset();
    req_v_i = 1; req_data_i = 96'h99;
    repeat (2) tick();
    fence_i = 1;
    mid();
    checks++; if (req_ready_and_o !== 1'b0) begin errors++; $display("FAIL fn_ready: got %0b want 0", req_ready_and_o); end
    checks++; if (fence_done_o !== 1'b0) begin errors++; $display("FAIL fn_done_busy: got %0b want 0", fence_done_o); end
    checks++; if (credits_used_o !== 5'd2) begin errors++; $display("FAIL fn_credits: got %0d want 2", credits_used_o); end
    repeat (2) tick();
    rev_v_i = 1; rev_data_i = 48'hF1;
    tick(); mid();
    checks++; if (credits_used_o !== 5'd1 || fence_done_o !== 1'b0) begin errors++; $display("FAIL fn_one_back: got %0d done=%0b want 1 done=0", credits_used_o, fence_done_o); end
    rev_data_i = 48'hF2;
    tick();
    rev_v_i = 0;
    mid();
    checks++; if (fence_done_o !== 1'b1 || credits_used_o !== 5'd0) begin errors++; $display("FAIL fn_done: got done=%0b credits=%0d want done=1 credits=0", fence_done_o, credits_used_o); end
    checks++; if (req_ready_and_o !== 1'b0 || error_o !== 1'b0) begin errors++; $display("FAIL fn_fenced: got ready=%0b err=%0b want 0 0", req_ready_and_o, error_o); end
    rev_v_i = 1; rev_data_i = 48'hF3;
    tick();
    rev_v_i = 0;
    mid();
    checks++; if (error_o !== 1'b1) begin errors++; $display("FAIL uf_error: got %0b want 1", error_o); end
    checks++; if (credits_used_o !== 5'd0) begin errors++; $display("FAIL uf_credits: got %0d want 0", credits_used_o); end
    repeat (3) tick();
    req_v_i = 0;
    mid();
    checks++; if (error_o !== 1'b1) begin errors++; $display("FAIL uf_sticky: got %0b want 1", error_o); end
    resp_yumi_i = 1;
    for (int i = 1; i <= 3; i++) begin
      #1;
      checks++; if (resp_v_o !== 1'b1 || resp_data_o !== RW'(48'hF0 + i)) begin errors++; $display("FAIL uf_buffered_%0d: got v=%0b data=%0h want %0h", i, resp_v_o, resp_data_o, 48'hF0 + i); end
      tick();
    end
    resp_yumi_i = 0;
    fence_i = 0;
    #1;
    checks++; if (req_ready_and_o !== 1'b1) begin errors++; $display("FAIL fn_unfenced_ready: got %0b want 1", req_ready_and_o); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
    test_reset();
    test_credit_exhaustion();
    test_simultaneous();
    test_backpressure();
    test_rev_full();
    test_fence_underflow();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
